// File: rtl/and_gate_pkg.sv
// Shared leaf-library constants for the and_gate primitive.
package and_gate_pkg;

    // Default width of the saturating hit counter.
    localparam int unsigned AND_GATE_CNT_W = 16;

endpackage : and_gate_pkg

// File: rtl/and_gate_hit_cnt.sv
// Saturating event counter with a synchronous clear that beats increment.
module and_gate_hit_cnt
    import and_gate_pkg::*;
#(
    parameter int unsigned CNT_W = AND_GATE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise step unless already all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : and_gate_hit_cnt

// File: rtl/and_gate.sv
// Bitwise AND with a combinational result, a qualified registered copy,
// an all-ones hit flag and a saturating hit counter.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = AND_GATE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    input  logic             in_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] z_q,
    output logic             out_valid,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [WIDTH-1:0] and_val;
    logic             all_ones;
    logic [WIDTH-1:0] z_q_r;
    logic             hit_r;
    logic             out_valid_r;

    // Pure gate path: no clock, reset or qualifier involvement.
    assign and_val  = x & y;
    assign z        = and_val;
    assign all_ones = &and_val;

    // Capture the qualified sample; valid tracks in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q_r       <= '0;
            hit_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                z_q_r <= and_val;
                hit_r <= all_ones;
            end
        end
    end

    assign z_q       = z_q_r;
    assign hit       = hit_r;
    assign out_valid = out_valid_r;

    and_gate_hit_cnt #(
        .CNT_W(CNT_W)
    ) u_hit_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (in_valid && all_ones),
        .cnt  (hit_cnt)
    );

endmodule : and_gate

// File: tb/tb_and_gate.sv
// Directed, table-driven bench for and_gate across three parameterisations.
module tb_and_gate;

    logic clk;
    logic clk_en;
    logic rst_n;
    logic in_valid;
    logic clr;

    // WIDTH=1 instance for the truth table.
    logic       x1, y1, z1, zq1, ov1, hit1;
    logic [15:0] cnt1;

    // WIDTH=8 instances: default counter and a 2-bit counter.
    logic [7:0]  x8, y8, z8, zq8, zs, zqs;
    logic        ov8, hit8, ovs, hits;
    logic [15:0] cnt8;
    logic [1:0]  cnts;

    int total = 0;
    int bad   = 0;

    and_gate #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .z(z1), .in_valid(in_valid),
        .clr(clr), .z_q(zq1), .out_valid(ov1), .hit(hit1), .hit_cnt(cnt1)
    );

    and_gate #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .x(x8), .y(y8), .z(z8), .in_valid(in_valid),
        .clr(clr), .z_q(zq8), .out_valid(ov8), .hit(hit8), .hit_cnt(cnt8)
    );

    and_gate #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .x(x8), .y(y8), .z(zs), .in_valid(in_valid),
        .clr(clr), .z_q(zqs), .out_valid(ovs), .hit(hits), .hit_cnt(cnts)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        iv;
        logic        clr;
        logic [7:0]  z;
        logic [7:0]  zq;
        logic        hit;
        logic        ov;
        logic [15:0] cnt;
        logic [1:0]  sat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // Registered-path vectors, expectations computed by hand.
        vecs[0] = '{8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 8'h30, 1'b0, 1'b1, 16'd0, 2'd0};
        vecs[1] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'd1, 2'd1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'd2, 2'd2};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'd3, 2'd3};
        vecs[4] = '{8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 16'd3, 2'd3};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'd0, 2'd0};
        vecs[6] = '{8'hAA, 8'hFF, 1'b1, 1'b0, 8'hAA, 8'hAA, 1'b0, 1'b1, 16'd0, 2'd0};

        clk_en   = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        x1 = 1'b0; y1 = 1'b0;
        x8 = 8'h00; y8 = 8'h00;

        // Truth table with the clock idle and reset held.
        for (int i = 0; i < 4; i++) begin
            x1 = i[1];
            y1 = i[0];
            #10;
            check("truth_z", {31'd0, z1}, {31'd0, (i == 3) ? 1'b1 : 1'b0});
        end

        check("rst_zq", {24'd0, zq8}, 32'd0);
        check("rst_hit", {31'd0, hit8}, 32'd0);
        check("rst_ov", {31'd0, ov8}, 32'd0);
        check("rst_cnt", {16'd0, cnt8}, 32'd0);

        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            x8       = vecs[i].x;
            y8       = vecs[i].y;
            in_valid = vecs[i].iv;
            clr      = vecs[i].clr;
            #1;
            check("vec_z", {24'd0, z8}, {24'd0, vecs[i].z});
            @(posedge clk);
            #1;
            check("vec_zq", {24'd0, zq8}, {24'd0, vecs[i].zq});
            check("vec_hit", {31'd0, hit8}, {31'd0, vecs[i].hit});
            check("vec_ov", {31'd0, ov8}, {31'd0, vecs[i].ov});
            check("vec_cnt", {16'd0, cnt8}, {16'd0, vecs[i].cnt});
            check("vec_sat", {30'd0, cnts}, {30'd0, vecs[i].sat});
        end

        // Five qualifying samples: 2-bit counter pins at 3, 16-bit reaches 5.
        @(negedge clk);
        x8 = 8'hFF; y8 = 8'hFF; in_valid = 1'b1; clr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("sat_cnt2", {30'd0, cnts}, 32'd3);
        check("sat_cnt16", {16'd0, cnt8}, 32'd5);

        // Asynchronous reset between edges while the gate keeps working.
        @(negedge clk);
        x8 = 8'h5A; y8 = 8'hFF; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_zq", {24'd0, zq8}, 32'd0);
        check("arst_hit", {31'd0, hit8}, 32'd0);
        check("arst_ov", {31'd0, ov8}, 32'd0);
        check("arst_cnt", {16'd0, cnt8}, 32'd0);
        check("arst_sat", {30'd0, cnts}, 32'd0);
        check("arst_z", {24'd0, z8}, 32'h5A);
        x8 = 8'h0F;
        #1;
        check("arst_z_track", {24'd0, z8}, 32'h0F);
        @(posedge clk);
        #1;
        check("arst_hold_zq", {24'd0, zq8}, 32'd0);

        // First edge after release samples normally.
        @(negedge clk);
        rst_n = 1'b1;
        x8 = 8'hFF; y8 = 8'hFF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rel_zq", {24'd0, zq8}, 32'hFF);
        check("rel_hit", {31'd0, hit8}, 32'd1);
        check("rel_ov", {31'd0, ov8}, 32'd1);
        check("rel_cnt", {16'd0, cnt8}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_and_gate
